// File: rtl/pred_pht_pkg.sv
// Shared definitions for the IFU pattern history table.
//   - pht_state_e : init-sweep / live state of the table controller
//   - PRED_CNT_W  : default saturating-counter width
//   - CNT2_*      : classic 2-bit counter encodings (CNT_W = 2)
//   - init_cnt()  : weakly-not-taken initial value for a given counter width
package pred_pht_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } pht_state_e;

  localparam int PRED_CNT_W = 2;

  localparam logic [1:0] CNT2_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT2_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT2_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT2_STRONG_T  = 2'b11;

  // Largest value whose MSB is clear: the weakest not-taken state.
  function automatic int init_cnt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/pred_sat_cnt.sv
// Saturating up/down counter step (combinational).
//   cnt_i   : current counter value
//   taken_i : resolved branch direction (1 = count up, 0 = count down)
//   cnt_o   : next counter value, clamped to [0, 2**CNT_W-1]
// For CNT_W = 2 this reproduces the strong/weak taken/not-taken FSM.
module pred_sat_cnt
  import pred_pht_pkg::*;
#(
  parameter int CNT_W = PRED_CNT_W
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != CNT_MAX) cnt_o = cnt_i + CNT_ONE;
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - CNT_ONE;
    end
  end

endmodule

// File: rtl/pred_pht.sv
// Pattern history table for the IFU branch predictor.
// 2**INDEX_W saturating counters, optionally gshare-indexed, with a
// 1-cycle prediction port and a commit-time update port. After reset the
// table is filled with INIT_CNT by an internal sweep before going live.
//   clk, rst              : clock, synchronous active-high reset
//   ready                 : init sweep finished, ports live
//   pred_req, pred_pc     : prediction request
//   resp_valid/taken/cnt  : prediction response, one cycle after request
//   resp_ghr              : history used to form the prediction index
//   upd_valid, upd_pc     : commit update of a resolved branch
//   upd_ghr, upd_taken    : history snapshot and resolved direction
//   ghr                   : non-speculative global history register
module pred_pht
  import pred_pht_pkg::*;
#(
  parameter int INDEX_W    = 8,
  parameter int CNT_W      = PRED_CNT_W,
  parameter int GHR_W      = 8,
  parameter bit USE_GSHARE = 1'b1,
  parameter int INIT_CNT   = init_cnt(CNT_W)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             pred_req,
  input  logic [31:0]      pred_pc,
  output logic             resp_valid,
  output logic             resp_taken,
  output logic [CNT_W-1:0] resp_cnt,
  output logic [GHR_W-1:0] resp_ghr,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_taken,
  output logic [GHR_W-1:0] ghr
);

  localparam int                 DEPTH    = 1 << INDEX_W;
  localparam logic [CNT_W-1:0]   INIT_VAL = CNT_W'(INIT_CNT);
  localparam logic [INDEX_W-1:0] LAST_IDX = '1;
  localparam logic [INDEX_W-1:0] IDX_ONE  = INDEX_W'(1);

  pht_state_e         state_q, state_d;
  logic [INDEX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic [GHR_W-1:0]   ghr_q, ghr_d, ghr_shift;
  logic               resp_valid_q;
  logic               resp_taken_q;
  logic [CNT_W-1:0]   resp_cnt_q;
  logic [GHR_W-1:0]   resp_ghr_q;

  // Reset-free storage; contents are defined by the init sweep alone.
  logic [CNT_W-1:0]   table_q [DEPTH];

  logic               live;
  logic               pred_fire, upd_fire, sweep_we;
  logic [INDEX_W-1:0] pred_pcb, upd_pcb, pred_h, upd_h;
  logic [INDEX_W-1:0] pred_idx, upd_idx;
  logic [CNT_W-1:0]   upd_cur, upd_next, pred_rd;
  logic               unused_pc_bits;

  assign live      = (state_q == ST_READY);
  assign pred_fire = pred_req & live;
  assign upd_fire  = upd_valid & live;
  assign sweep_we  = (state_q == ST_INIT) & ~rst;

  // Index formation: word-aligned PC bits, optionally folded with history.
  assign pred_pcb = pred_pc[INDEX_W+1:2];
  assign upd_pcb  = upd_pc[INDEX_W+1:2];

  always_comb begin
    pred_h = '0;
    upd_h  = '0;
    pred_h[GHR_W-1:0] = ghr_q;
    upd_h[GHR_W-1:0]  = upd_ghr;
  end

  assign pred_idx = USE_GSHARE ? (pred_pcb ^ pred_h) : pred_pcb;
  assign upd_idx  = USE_GSHARE ? (upd_pcb ^ upd_h) : upd_pcb;

  assign unused_pc_bits = ^{pred_pc[31:INDEX_W+2], pred_pc[1:0],
                            upd_pc[31:INDEX_W+2], upd_pc[1:0]};

  assign upd_cur = table_q[upd_idx];

  pred_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sat (
    .cnt_i  (upd_cur),
    .taken_i(upd_taken),
    .cnt_o  (upd_next)
  );

  // Write-first: a same-cycle update to the predicted entry is forwarded.
  assign pred_rd = (upd_fire && (upd_idx == pred_idx)) ? upd_next : table_q[pred_idx];

  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign ghr_shift = upd_taken;
    end else begin : g_ghr_wide
      assign ghr_shift = {ghr_q[GHR_W-2:0], upd_taken};
    end
  endgenerate

  assign ghr_d = upd_fire ? ghr_shift : ghr_q;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      ST_INIT: begin
        sweep_idx_d = sweep_idx_q + IDX_ONE;
        if (sweep_idx_q == LAST_IDX) state_d = ST_READY;
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      sweep_idx_q  <= '0;
      ghr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_cnt_q   <= '0;
      resp_ghr_q   <= '0;
    end else begin
      state_q      <= state_d;
      sweep_idx_q  <= sweep_idx_d;
      ghr_q        <= ghr_d;
      resp_valid_q <= pred_fire;
      if (pred_fire) begin
        resp_cnt_q   <= pred_rd;
        resp_taken_q <= pred_rd[CNT_W-1];
        resp_ghr_q   <= ghr_q;
      end
    end
  end

  // Table write port: the sweep owns it until the table goes live.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      table_q[sweep_idx_q] <= INIT_VAL;
    end else if (upd_fire && !rst) begin
      table_q[upd_idx] <= upd_next;
    end
  end

  assign ready      = live;
  assign resp_valid = resp_valid_q;
  assign resp_taken = resp_taken_q;
  assign resp_cnt   = resp_cnt_q;
  assign resp_ghr   = resp_ghr_q;
  assign ghr        = ghr_q;

endmodule
